// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_PID      = 3'd2,
    ST_DATA     = 3'd3,
    ST_EOP_SE0A = 3'd4,
    ST_EOP_SE0B = 3'd5,
    ST_EOP_J    = 3'd6
  } tx_seq_state_t;

  // 0000_0001 on the wire, LSB first.
  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam int unsigned STUFF_LIMIT  = 6;
  localparam int unsigned EOP_SE0_BITS = 2;

  // PID byte: check nibble (inverted PID) in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_bit_stuffer.sv
// Ones-run tracker for USB bit stuffing. stuff_next is a lookahead:
// it is high while the bit now on the line completes a run of
// STUFF_LIMIT ones, so the sequencer can decide at that same bit_en
// to send a stuffed 0 in the following bit period.
module usb_tx_bit_stuffer
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enable,
  input  logic bit_en,
  input  logic sent_bit,
  output logic stuff_next
);

  localparam logic [2:0] ONES_MAX  = 3'(STUFF_LIMIT);
  localparam logic [2:0] ONES_LAST = 3'(STUFF_LIMIT - 1);

  logic [2:0] ones_r;

  // Count consecutive sent ones; any sent 0 (stuffed or not) clears the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_r <= 3'd0;
    end else if (clr) begin
      ones_r <= 3'd0;
    end else if (enable && bit_en) begin
      if (sent_bit && (ones_r != ONES_MAX)) begin
        ones_r <= ones_r + 3'd1;
      end else begin
        ones_r <= 3'd0;
      end
    end
  end

  assign stuff_next = enable & sent_bit & (ones_r == ONES_LAST);

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit packet sequencer: SYNC, PID, payload bytes and EOP,
// one bit per bit_en, with bit stuffing and one-byte payload prefetch.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter  int MAX_BYTES = 64,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             bit_en,
  input  logic [7:0]       tx_byte,
  output logic             clock_run,
  output logic             get_tx_byte,
  output logic             tx_bit,
  output logic             tx_se0,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  tx_seq_state_t    state_r, state_nxt_s, adv_state_s;
  logic [7:0]       shift_r, shift_nxt_s, adv_shift_s;
  logic [2:0]       bit_cnt_r, bit_cnt_nxt_s, adv_cnt_s;
  logic [LEN_W-1:0] bytes_left_r, bytes_left_nxt_s, adv_left_s;
  logic [LEN_W-1:0] len_clamped_s;
  logic [3:0]       pid_r, pid_nxt_s;
  logic [7:0]       prefetch_r;
  logic             fetch_pend_r;
  logic             stuffing_r, stuffing_nxt_s;
  logic             adv_bit_s, adv_se0_s, adv_get_s;
  logic             tx_bit_r, tx_bit_nxt_s;
  logic             tx_se0_r, tx_se0_nxt_s;
  logic             clock_run_r, clock_run_nxt_s;
  logic             get_r, get_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             start_s, stuff_en_s, stuff_next_s;

  // Requested lengths beyond the buffer size are clamped.
  always_comb begin
    if (tx_len > LEN_MAX) begin
      len_clamped_s = LEN_MAX;
    end else begin
      len_clamped_s = tx_len;
    end
  end

  // Stuffing covers SYNC through the last payload bit (incl. a trailing stuff bit).
  always_comb begin
    case (state_r)
      ST_SYNC, ST_PID, ST_DATA: stuff_en_s = 1'b1;
      default:                  stuff_en_s = 1'b0;
    endcase
  end

  usb_tx_bit_stuffer u_stuffer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_s),
    .enable    (stuff_en_s),
    .bit_en    (bit_en),
    .sent_bit  (tx_bit_r),
    .stuff_next(stuff_next_s)
  );

  // What follows the real bit now on the line: next bit of the field, or next field.
  always_comb begin
    adv_state_s = state_r;
    adv_shift_s = {1'b0, shift_r[7:1]};
    adv_bit_s   = shift_r[1];
    adv_cnt_s   = bit_cnt_r + 3'd1;
    adv_left_s  = bytes_left_r;
    adv_get_s   = 1'b0;
    adv_se0_s   = 1'b0;
    if (bit_cnt_r != 3'd7) begin
      adv_cnt_s = bit_cnt_r + 3'd1;
    end else if (state_r == ST_SYNC) begin
      // PID load; start fetching the first payload byte behind it.
      adv_state_s = ST_PID;
      adv_shift_s = pid_byte(pid_r);
      adv_bit_s   = pid_r[0];
      adv_cnt_s   = 3'd0;
      adv_get_s   = (bytes_left_r != LEN_ZERO);
    end else if (bytes_left_r != LEN_ZERO) begin
      // Payload load from the prefetch register; refill it if more remain.
      adv_state_s = ST_DATA;
      adv_shift_s = prefetch_r;
      adv_bit_s   = prefetch_r[0];
      adv_cnt_s   = 3'd0;
      adv_left_s  = bytes_left_r - LEN_ONE;
      adv_get_s   = (bytes_left_r != LEN_ONE);
    end else begin
      adv_state_s = ST_EOP_SE0A;
      adv_shift_s = shift_r;
      adv_bit_s   = 1'b1;
      adv_cnt_s   = 3'd0;
      adv_se0_s   = 1'b1;
    end
  end

  // Next-state and next-output logic for the packet FSM.
  always_comb begin
    state_nxt_s      = state_r;
    shift_nxt_s      = shift_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    bytes_left_nxt_s = bytes_left_r;
    pid_nxt_s        = pid_r;
    stuffing_nxt_s   = stuffing_r;
    tx_bit_nxt_s     = tx_bit_r;
    tx_se0_nxt_s     = tx_se0_r;
    clock_run_nxt_s  = clock_run_r;
    busy_nxt_s       = busy_r;
    get_nxt_s        = 1'b0;
    done_nxt_s       = 1'b0;
    start_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_start) begin
          start_s          = 1'b1;
          pid_nxt_s        = tx_pid;
          bytes_left_nxt_s = len_clamped_s;
          shift_nxt_s      = SYNC_BYTE;
          bit_cnt_nxt_s    = 3'd0;
          stuffing_nxt_s   = 1'b0;
          tx_bit_nxt_s     = SYNC_BYTE[0];
          tx_se0_nxt_s     = 1'b0;
          clock_run_nxt_s  = 1'b1;
          busy_nxt_s       = 1'b1;
          state_nxt_s      = ST_SYNC;
        end else begin
          tx_bit_nxt_s = 1'b1;
          tx_se0_nxt_s = 1'b0;
        end
      end
      ST_SYNC, ST_PID, ST_DATA: begin
        if (bit_en && (stuffing_r || !stuff_next_s)) begin
          // A real bit (or the stuff bit) ends: shift/load as pending.
          stuffing_nxt_s   = 1'b0;
          state_nxt_s      = adv_state_s;
          shift_nxt_s      = adv_shift_s;
          bit_cnt_nxt_s    = adv_cnt_s;
          bytes_left_nxt_s = adv_left_s;
          get_nxt_s        = adv_get_s;
          tx_bit_nxt_s     = adv_bit_s;
          tx_se0_nxt_s     = adv_se0_s;
        end else if (bit_en) begin
          // Run of ones complete: insert a 0, shift register and count hold.
          stuffing_nxt_s = 1'b1;
          tx_bit_nxt_s   = 1'b0;
        end else begin
          stuffing_nxt_s = stuffing_r;
        end
      end
      ST_EOP_SE0A: begin
        if (bit_en) begin
          state_nxt_s = ST_EOP_SE0B;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_EOP_SE0B: begin
        if (bit_en) begin
          state_nxt_s  = ST_EOP_J;
          tx_se0_nxt_s = 1'b0;
          tx_bit_nxt_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_EOP_J: begin
        if (bit_en) begin
          state_nxt_s     = ST_IDLE;
          done_nxt_s      = 1'b1;
          clock_run_nxt_s = 1'b0;
          busy_nxt_s      = 1'b0;
          tx_bit_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        clock_run_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        tx_bit_nxt_s    = 1'b1;
        tx_se0_nxt_s    = 1'b0;
      end
    endcase
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      bytes_left_r <= LEN_ZERO;
      pid_r        <= 4'h0;
      stuffing_r   <= 1'b0;
      tx_bit_r     <= 1'b1;
      tx_se0_r     <= 1'b0;
      clock_run_r  <= 1'b0;
      get_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shift_r      <= shift_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      bytes_left_r <= bytes_left_nxt_s;
      pid_r        <= pid_nxt_s;
      stuffing_r   <= stuffing_nxt_s;
      tx_bit_r     <= tx_bit_nxt_s;
      tx_se0_r     <= tx_se0_nxt_s;
      clock_run_r  <= clock_run_nxt_s;
      get_r        <= get_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  // Capture the buffer byte the cycle after the read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pend_r <= 1'b0;
      prefetch_r   <= 8'h00;
    end else begin
      fetch_pend_r <= get_r;
      if (fetch_pend_r) begin
        prefetch_r <= tx_byte;
      end
    end
  end

  assign clock_run   = clock_run_r;
  assign get_tx_byte = get_r;
  assign tx_bit      = tx_bit_r;
  assign tx_se0      = tx_se0_r;
  assign tx_busy     = busy_r;
  assign tx_done     = done_r;

endmodule
